// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending-machine controller.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'd0,
      COIN_NICKEL  = 2'd1,
      COIN_DIME    = 2'd2,
      COIN_QUARTER = 2'd3
   } coin_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      VEND,
      CHANGE
   } state_t;

   localparam int unsigned NICKEL_VAL  = 5;
   localparam int unsigned DIME_VAL    = 10;
   localparam int unsigned QUARTER_VAL = 25;

endpackage

// File: rtl/change_selector.sv
// Greedy coin picker: the largest coin not exceeding the remaining credit.
// Purely combinational; NICKEL is returned for any credit below a dime.
module change_selector
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] credit,
   output coin_t               coin,
   output logic [CREDIT_W-1:0] value
);

   always_comb begin
      coin  = COIN_NICKEL;
      value = CREDIT_W'(NICKEL_VAL);
      if (credit >= CREDIT_W'(QUARTER_VAL)) begin
         coin  = COIN_QUARTER;
         value = CREDIT_W'(QUARTER_VAL);
      end else if (credit >= CREDIT_W'(DIME_VAL)) begin
         coin  = COIN_DIME;
         value = CREDIT_W'(DIME_VAL);
      end
   end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, vends on request, and pays out
// change or refunds one coin at a time through a req/ack ejector handshake.
module vend_controller
   import vend_pkg::*;
#(
   parameter int unsigned PRICE           = 65,
   parameter int unsigned MAX_CREDIT      = 200,
   parameter int unsigned CREDIT_W        = 8,
   parameter int unsigned DISPENSE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                dimeDetected,
   input  logic                nickelDetected,
   input  logic                quarterDetected,
   input  logic                selectBtn,
   input  logic                cancelBtn,
   input  logic                ejectAck,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic                ejectReq,
   output logic [1:0]          ejectCoin,
   output logic                coinReject,
   output logic                busy
);

   localparam int unsigned         CNT_W    = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
   localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DISPENSE_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dispense_q, dispense_d;
   logic                eject_req_q, eject_req_d;
   coin_t               eject_coin_q, eject_coin_d;
   logic                coin_reject_q, coin_reject_d;
   logic                busy_q, busy_d;

   coin_t               sel_coin;
   logic [CREDIT_W-1:0] sel_val;

   logic [1:0]          n_pulse;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   sum;
   logic                coin_ok;
   logic [CREDIT_W-1:0] credit_new;

   change_selector #(
      .CREDIT_W (CREDIT_W)
   ) u_change_selector (
      .credit (credit_q),
      .coin   (sel_coin),
      .value  (sel_val)
   );

   // A coin is taken only when it arrives alone, in a coin-accepting state,
   // and does not push the credit past the ceiling.
   always_comb begin
      n_pulse = {1'b0, dimeDetected} + {1'b0, nickelDetected} + {1'b0, quarterDetected};
      coin_val = '0;
      if (quarterDetected)     coin_val = CREDIT_W'(QUARTER_VAL);
      else if (dimeDetected)   coin_val = CREDIT_W'(DIME_VAL);
      else if (nickelDetected) coin_val = CREDIT_W'(NICKEL_VAL);
      sum     = {1'b0, credit_q} + {1'b0, coin_val};
      coin_ok = ((state_q == IDLE) || (state_q == ACCUM)) && (n_pulse == 2'd1) && (sum <= MAX_C);
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      cnt_d         = cnt_q;
      dispense_d    = 1'b0;
      eject_req_d   = eject_req_q;
      eject_coin_d  = eject_coin_q;
      coin_reject_d = (n_pulse != 2'd0) && !coin_ok;
      credit_new    = credit_q;

      case (state_q)
         IDLE, ACCUM: begin
            credit_new = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
            credit_d   = credit_new;
            if ((state_q == ACCUM) && cancelBtn) begin
               state_d = CHANGE;
            end else if ((state_q == ACCUM) && selectBtn && (credit_new >= PRICE_C)) begin
               state_d    = VEND;
               cnt_d      = '0;
               dispense_d = 1'b1;
            end else begin
               state_d = (credit_new != '0) ? ACCUM : IDLE;
            end
         end
         VEND: begin
            if (cnt_q == LAST_CNT) begin
               credit_d = credit_q - PRICE_C;
               state_d  = (credit_q != PRICE_C) ? CHANGE : IDLE;
            end else begin
               cnt_d      = cnt_q + 1'b1;
               dispense_d = 1'b1;
            end
         end
         CHANGE: begin
            // Credit is frozen while a request is open, so the selector output
            // still matches the coin currently offered to the ejector.
            if (eject_req_q) begin
               if (ejectAck) begin
                  eject_req_d = 1'b0;
                  credit_d    = credit_q - sel_val;
                  if (credit_q == sel_val) begin
                     state_d      = IDLE;
                     eject_coin_d = COIN_NONE;
                  end
               end
            end else begin
               eject_req_d  = 1'b1;
               eject_coin_d = sel_coin;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == VEND) || (state_d == CHANGE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         cnt_q         <= '0;
         dispense_q    <= 1'b0;
         eject_req_q   <= 1'b0;
         eject_coin_q  <= COIN_NONE;
         coin_reject_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         cnt_q         <= cnt_d;
         dispense_q    <= dispense_d;
         eject_req_q   <= eject_req_d;
         eject_coin_q  <= eject_coin_d;
         coin_reject_q <= coin_reject_d;
         busy_q        <= busy_d;
      end
   end

   assign credit     = credit_q;
   assign dispense   = dispense_q;
   assign ejectReq   = eject_req_q;
   assign ejectCoin  = eject_coin_q;
   assign coinReject = coin_reject_q;
   assign busy       = busy_q;

endmodule
